// File: rtl/regfile_pkg.sv
// Shared widths and constants for the architectural register file and its cycle counter.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t REG_ZERO = '0;

    // An unknown wen compares as not-1 and is therefore treated as no write.
    function automatic logic write_valid(input logic wen, input addr_t waddr);
        return (wen == 1'b1) && (waddr != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_cycle_counter_if.sv
// Core-side bus of the register file: read/write ports, halt, cycle count and timeout.
interface regfile_cycle_counter_if #(
    parameter int CNT_W = 32
);
    import regfile_pkg::*;

    addr_t            raddr0;
    data_t            rdata0;
    addr_t            raddr1;
    data_t            rdata1;
    logic             wen;
    addr_t            waddr;
    data_t            wdata;
    logic             halt;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout;

    modport master (
        output raddr0, raddr1, wen, waddr, wdata, halt,
        input  rdata0, rdata1, cycle_count, timeout
    );

    modport slave (
        input  raddr0, raddr1, wen, waddr, wdata, halt,
        output rdata0, rdata1, cycle_count, timeout
    );

endinterface

// File: rtl/regfile_cycle_counter_cycle_counter.sv
// Saturating free-running cycle counter that freezes on halt and latches a sticky timeout.
module cycle_counter #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_SAT       = '1;
    localparam bit               MAX_REACHABLE = (CNT_W >= 32) || (MAX_CYCLES < (1 << CNT_W));
    localparam logic [CNT_W-1:0] MAX_VAL       = CNT_W'(MAX_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             timeout_q;
    logic             timeout_d;

    // Timeout rises on the same edge that lands the count on MAX_CYCLES, then both freeze.
    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q;
        if (!halt && !timeout_q && (count_q != CNT_SAT)) begin
            count_d = count_q + 1'b1;
            if (MAX_REACHABLE && (count_d == MAX_VAL)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign cycle_count = count_q;
    assign timeout     = timeout_q;

endmodule

// File: rtl/regfile_cycle_counter.sv
// 16 x 16-bit register file (2R/1W, registered reads, r0 hardwired to zero) plus cycle counter.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read port.
module regfile_cycle_counter
    import regfile_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_cycle_counter_if.slave bus
);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];
    data_t rdata0_q;
    data_t rdata0_d;
    data_t rdata1_q;
    data_t rdata1_d;
    logic  wr_en;

    assign wr_en = write_valid(bus.wen, bus.waddr);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.waddr] = bus.wdata;
        end
        regs_d[REG_ZERO] = '0;
    end

    always_comb begin
        rdata0_d = regs_q[bus.raddr0];
        rdata1_d = regs_q[bus.raddr1];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes r0, so a read of r0 is never bypassed.
        if (wr_en && (bus.waddr == bus.raddr0)) begin
            rdata0_d = bus.wdata;
        end
        if (wr_en && (bus.waddr == bus.raddr1)) begin
            rdata1_d = bus.wdata;
        end
`else
        // Read-before-write: the core forwards same-edge write data itself.
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            regs_q   <= regs_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

    cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (bus.halt),
        .cycle_count (bus.cycle_count),
        .timeout     (bus.timeout)
    );

endmodule

// File: tb/tb_regfile_cycle_counter.sv
// Self-checking bench for regfile_cycle_counter: directed table, corner sequences, random vs model.
module tb_regfile_cycle_counter;
    import regfile_pkg::*;

    localparam int CNT_W   = 32;
    localparam int MAX_CYC = 20;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    regfile_cycle_counter_if #(.CNT_W(CNT_W)) bus ();

    regfile_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: register contents, expected registered read data, non-halted edge count.
    int unsigned m_regs [16];
    int unsigned m_rd0;
    int unsigned m_rd1;
    int          m_active;

    typedef struct {
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        bit          we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_read(input logic [3:0] ra, input logic [3:0] wa,
                                               input bit we, input logic [15:0] wd);
        if (ra == 4'd0) return 0;
        if (BYPASS && we && (wa == ra)) return int'(wd);
        return m_regs[ra];
    endfunction

    function automatic int unsigned exp_count();
        return (m_active < MAX_CYC) ? m_active : MAX_CYC;
    endfunction

    task automatic step(input logic [3:0] ra0, input logic [3:0] ra1, input bit we,
                        input logic [3:0] wa, input logic [15:0] wd, input bit hlt);
        bus.raddr0 = ra0;
        bus.raddr1 = ra1;
        bus.wen    = we;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.halt   = hlt;
        @(posedge clk);
        m_rd0 = model_read(ra0, wa, we, wd);
        m_rd1 = model_read(ra1, wa, we, wd);
        if (we && (wa != 4'd0)) m_regs[wa] = int'(wd);
        if (!hlt) m_active++;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rdata0"}, 32'(bus.rdata0), m_rd0);
        check({tag, ".rdata1"}, 32'(bus.rdata1), m_rd1);
        check({tag, ".cycle_count"}, bus.cycle_count, exp_count());
        check({tag, ".timeout"}, 32'(bus.timeout), (m_active >= MAX_CYC) ? 1 : 0);
    endtask

    // Reset is asserted away from a clock edge and its effect is checked before any edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_rd0    = 0;
        m_rd1    = 0;
        m_active = 0;
        check("rst.rdata0", 32'(bus.rdata0), 0);
        check("rst.rdata1", 32'(bus.rdata1), 0);
        check("rst.cycle_count", bus.cycle_count, 0);
        check("rst.timeout", 32'(bus.timeout), 0);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0] = '{4'd0,  4'd1,  1'b1, 4'd3,  16'hBEEF, 16'h0000, 16'h0000};
        vecs[1] = '{4'd3,  4'd3,  1'b1, 4'd15, 16'h8001, 16'hBEEF, 16'hBEEF};
        vecs[2] = '{4'd15, 4'd0,  1'b1, 4'd0,  16'h1234, 16'h8001, 16'h0000};
        vecs[3] = '{4'd0,  4'd15, 1'b0, 4'd3,  16'hFFFF, 16'h0000, 16'h8001};
        vecs[4] = '{4'd3,  4'd2,  1'b1, 4'd7,  16'h0011, 16'hBEEF, 16'h0000};
        vecs[5] = '{4'd7,  4'd3,  1'b0, 4'd0,  16'h0000, 16'h0011, 16'hBEEF};

        bus.raddr0 = '0;
        bus.raddr1 = '0;
        bus.wen    = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.halt   = 1'b0;
        #2;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b0);
            check($sformatf("vec%0d.rdata0", i), 32'(bus.rdata0), 32'(vecs[i].e0));
            check($sformatf("vec%0d.rdata1", i), 32'(bus.rdata1), 32'(vecs[i].e1));
        end

        // Same-edge write and read of r7 (old 0x0011, new 0x2222).
        step(4'd7, 4'd7, 1'b1, 4'd7, 16'h2222, 1'b0);
        check("r7_same_edge.rdata0", 32'(bus.rdata0), BYPASS ? 32'h2222 : 32'h0011);
        check("r7_same_edge.rdata1", 32'(bus.rdata1), BYPASS ? 32'h2222 : 32'h0011);
        step(4'd7, 4'd7, 1'b0, 4'd0, 16'h0000, 1'b0);
        check("r7_next_edge.rdata0", 32'(bus.rdata0), 32'h2222);
        check("r7_next_edge.rdata1", 32'(bus.rdata1), 32'h2222);

        // Same-edge write to r0 must not bypass.
        step(4'd0, 4'd0, 1'b1, 4'd0, 16'h5555, 1'b0);
        check("r0_same_edge.rdata0", 32'(bus.rdata0), 32'h0000);
        step(4'd7, 4'd7, 1'b0, 4'd0, 16'h0000, 1'b0);

        // Mid-run reset with nonzero read data, then previously written registers read as zero.
        apply_reset();
        step(4'd5, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0);
        check("post_rst.r5", 32'(bus.rdata0), 32'h0000);
        check("post_rst.r3", 32'(bus.rdata1), 32'h0000);

        apply_reset();
        repeat (10) step(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
        check("halt.run10", bus.cycle_count, 10);
        repeat (5) step(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1);
        check("halt.hold5", bus.cycle_count, 10);
        repeat (3) step(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
        check("halt.resume3", bus.cycle_count, 13);
        check("halt.timeout", 32'(bus.timeout), 0);

        apply_reset();
        for (int i = 1; i <= 25; i++) begin
            step(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
            check($sformatf("tmo.count@%0d", i), bus.cycle_count, (i < MAX_CYC) ? i : MAX_CYC);
            check($sformatf("tmo.flag@%0d", i), 32'(bus.timeout), (i >= MAX_CYC) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, i[0]);
            check($sformatf("tmo.hold_count%0d", i), bus.cycle_count, MAX_CYC);
            check($sformatf("tmo.hold_flag%0d", i), 32'(bus.timeout), 1);
        end
        apply_reset();

        for (int n = 0; n < 500; n++) begin
            logic [3:0]  wa;
            logic [3:0]  ra0;
            logic [3:0]  ra1;
            logic [15:0] wd;
            bit          we;
            bit          hlt;
            if ($urandom_range(0, 39) == 0) begin
                apply_reset();
            end else begin
                wa  = 4'($urandom_range(0, 15));
                wd  = 16'($urandom);
                we  = ($urandom_range(0, 2) != 0);
                hlt = ($urandom_range(0, 3) == 0);
                ra0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
                ra1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
                step(ra0, ra1, we, wa, wd, hlt);
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
